// File: rtl/tpu_package.sv
// Shared types and constants for the unified buffer write path.
// The tile edge and buffer address width are common to both UB controllers.
package tpu_package;

   localparam int UB_ADDR_W = 12;
   localparam int TILE_LOG2 = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } ub_wr_state_t;

endpackage

// File: rtl/ub_tile_addr_gen.sv
// Incremental tile-column-major address generator for UB writes.
// Walks row, tx, ty in arrival order and flags the final beat.
module ub_tile_addr_gen
   import tpu_package::*;
#(
   parameter int ADDR_W    = tpu_package::UB_ADDR_W,
   parameter int TILE_LOG2 = tpu_package::TILE_LOG2,
   parameter int CNT_W     = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [CNT_W-1:0]  ny_i,
   input  logic [CNT_W-1:0]  nx_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   localparam int STR_W = CNT_W + TILE_LOG2;
   localparam logic [ADDR_W-1:0] TILE = ADDR_W'(1 << TILE_LOG2);

   logic [TILE_LOG2-1:0] r_row;
   logic [CNT_W-2:0]     r_tx;
   logic [CNT_W-2:0]     r_ty;
   logic [CNT_W-1:0]     r_nx;
   logic [CNT_W-1:0]     r_ny;
   logic [STR_W-1:0]     r_stride;
   logic [ADDR_W-1:0]    r_row_base;
   logic [ADDR_W-1:0]    r_tile_base;

   logic [CNT_W-1:0] w_nx_m1;
   logic [CNT_W-1:0] w_ny_m1;
   logic             w_row_end;
   logic             w_tx_end;
   logic             w_ty_end;

   assign w_nx_m1   = r_nx - CNT_W'(1);
   assign w_ny_m1   = r_ny - CNT_W'(1);
   assign w_row_end = (r_row == '1);
   assign w_tx_end  = ({1'b0, r_tx} == w_nx_m1);
   assign w_ty_end  = ({1'b0, r_ty} == w_ny_m1);

   assign addr_o = r_tile_base + ADDR_W'(r_row);
   assign last_o = w_row_end & w_tx_end & w_ty_end;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_row       <= '0;
         r_tx        <= '0;
         r_ty        <= '0;
         r_nx        <= '0;
         r_ny        <= '0;
         r_stride    <= '0;
         r_row_base  <= '0;
         r_tile_base <= '0;
      end else if (load_i) begin
         r_row       <= '0;
         r_tx        <= '0;
         r_ty        <= '0;
         r_nx        <= nx_i;
         r_ny        <= ny_i;
         r_stride    <= {ny_i, {TILE_LOG2{1'b0}}};
         r_row_base  <= base_i;
         r_tile_base <= base_i;
      end else if (step_i) begin
         if (!w_row_end) begin
            r_row <= r_row + 1'b1;
         end else begin
            r_row <= '0;
            // next tile column sits one full tile-column (NY tiles) further on
            if (!w_tx_end) begin
               r_tx        <= r_tx + 1'b1;
               r_tile_base <= r_tile_base + ADDR_W'(r_stride);
            end else begin
               r_tx        <= '0;
               r_ty        <= r_ty + 1'b1;
               r_row_base  <= r_row_base + TILE;
               r_tile_base <= r_row_base + TILE;
            end
         end
      end
   end

endmodule

// File: rtl/unified_buffer_write_control_unit.sv
// Write-side controller: takes result words in sweep order and
// stores them in the tile-column-major UB layout.
module unified_buffer_write_control_unit
   import tpu_package::*;
#(
   parameter int ADDR_W    = tpu_package::UB_ADDR_W,
   parameter int DATA_W    = 256,
   parameter int DIM_W     = 9,
   parameter int TILE_LOG2 = tpu_package::TILE_LOG2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DIM_W-1:0]  H_DIM_i,
   input  logic [DIM_W-1:0]  W_DIM_i,
   input  logic [ADDR_W-1:0] unified_buffer_start_addr_wr_i,
   input  logic              result_valid_i,
   input  logic [DATA_W-1:0] result_data_i,
   output logic              result_ready_o,
   output logic              unified_buffer_write_en_o,
   output logic [ADDR_W-1:0] unified_buffer_addr_wr_o,
   output logic [DATA_W-1:0] unified_buffer_data_wr_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int CNT_W = DIM_W + 1 - TILE_LOG2;
   localparam logic [DIM_W:0] ROUND = (DIM_W+1)'((1 << TILE_LOG2) - 1);

   ub_wr_state_t r_state;

   logic              r_ready;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_busy;
   logic              r_done;

   logic [DIM_W:0]    w_h_sum;
   logic [DIM_W:0]    w_w_sum;
   logic [CNT_W-1:0]  w_ny;
   logic [CNT_W-1:0]  w_nx;
   logic              w_start;
   logic              w_zero;
   logic              w_load;
   logic              w_accept;
   logic [ADDR_W-1:0] w_addr;
   logic              w_last;

   assign w_h_sum = {1'b0, H_DIM_i} + ROUND;
   assign w_w_sum = {1'b0, W_DIM_i} + ROUND;
   assign w_ny    = CNT_W'(w_h_sum >> TILE_LOG2);
   assign w_nx    = CNT_W'(w_w_sum >> TILE_LOG2);

   assign w_start  = start_i && (r_state == IDLE);
   assign w_zero   = (H_DIM_i == '0) || (W_DIM_i == '0);
   assign w_load   = w_start && !w_zero;
   assign w_accept = (r_state == WRITE) && r_ready && result_valid_i;

   ub_tile_addr_gen #(
      .ADDR_W    (ADDR_W),
      .TILE_LOG2 (TILE_LOG2),
      .CNT_W     (CNT_W)
   ) u_addr_gen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (w_load),
      .step_i (w_accept),
      .base_i (unified_buffer_start_addr_wr_i),
      .ny_i   (w_ny),
      .nx_i   (w_nx),
      .addr_o (w_addr),
      .last_o (w_last)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_ready <= 1'b0;
         r_wr_en <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_busy <= 1'b1;
                  if (w_zero) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= WRITE;
                     r_ready <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (w_accept) begin
                  r_wr_en <= 1'b1;
                  r_addr  <= w_addr;
                  r_data  <= result_data_i;
                  if (w_last) begin
                     r_state <= DONE;
                     r_ready <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign result_ready_o            = r_ready;
   assign unified_buffer_write_en_o = r_wr_en;
   assign unified_buffer_addr_wr_o  = r_addr;
   assign unified_buffer_data_wr_o  = r_data;
   assign busy_o                    = r_busy;
   assign done_o                    = r_done;

endmodule

// File: tb/tb_unified_buffer_write_control_unit.sv
// Scoreboard bench for the UB write controller; expected writes come
// from the closed-form address rule applied to the sweep order.
module tb_unified_buffer_write_control_unit;

   localparam int AW  = 12;
   localparam int DW  = 256;
   localparam int DMW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DMW-1:0] h_dim = '0;
   logic [DMW-1:0] w_dim = '0;
   logic [AW-1:0] base = '0;
   logic          valid = 1'b0;
   logic [DW-1:0] data = '0;
   logic          ready_o;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy_o;
   logic          done_o;

   always #5 clk = ~clk;

   unified_buffer_write_control_unit dut (
      .clk_i                         (clk),
      .rst_i                         (rst),
      .start_i                       (start),
      .H_DIM_i                       (h_dim),
      .W_DIM_i                       (w_dim),
      .unified_buffer_start_addr_wr_i(base),
      .result_valid_i                (valid),
      .result_data_i                 (data),
      .result_ready_o                (ready_o),
      .unified_buffer_write_en_o     (wr_en),
      .unified_buffer_addr_wr_o      (wr_addr),
      .unified_buffer_data_wr_o      (wr_data),
      .busy_o                        (busy_o),
      .done_o                        (done_o)
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          done;
   } ev_t;

   ev_t           sbq[$];
   logic [DW-1:0] dq[$];
   int            checks = 0;
   int            errors = 0;
   logic          prev_acc = 1'b0;
   logic          mon_en = 1'b0;
   ev_t           m_e;

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every write/done must match the head of the scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         chk("wr_follows_accept", DW'(wr_en), DW'(prev_acc));
         if (wr_en || done_o) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: we=%0b done=%0b addr=%0h",
                        wr_en, done_o, wr_addr);
            end else begin
               m_e = sbq.pop_front();
               chk("we", DW'(wr_en), DW'(m_e.we));
               if (m_e.we) begin
                  chk("addr", DW'(wr_addr), DW'(m_e.addr));
                  chk("data", wr_data, m_e.data);
               end
               chk("done", DW'(done_o), DW'(m_e.done));
            end
         end
      end
      prev_acc = valid & ready_o & ~rst;
   end

   task automatic build(int h, int w, logic [AW-1:0] b);
      int   ny;
      int   nx;
      ev_t  e;
      logic [DW-1:0] d;
      dq.delete();
      if (h == 0 || w == 0) begin
         e.we = 1'b0; e.addr = '0; e.data = '0; e.done = 1'b1;
         sbq.push_back(e);
         return;
      end
      ny = (h + 31) / 32;
      nx = (w + 31) / 32;
      for (int ty = 0; ty < ny; ty++)
         for (int tx = 0; tx < nx; tx++)
            for (int row = 0; row < 32; row++) begin
               for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
               e.we   = 1'b1;
               e.addr = AW'(int'(b) + (tx * ny + ty) * 32 + row);
               e.data = d;
               e.done = (ty == ny-1) && (tx == nx-1) && (row == 31);
               sbq.push_back(e);
               dq.push_back(d);
            end
   endtask

   // mode 0: valid held, 1: pattern 1,0,0,1, 2: random
   task automatic run(int h, int w, logic [AW-1:0] b, int mode,
                      int rst_after, bit extra);
      int   k;
      int   total;
      int   budget;
      int   pat;
      logic acc;
      build(h, w, b);
      total = dq.size();
      @(posedge clk); #1;
      start = 1'b1; h_dim = DMW'(h); w_dim = DMW'(w); base = b;
      @(posedge clk); #1;
      start = 1'b0;
      h_dim = DMW'($urandom); w_dim = DMW'($urandom); base = AW'($urandom);
      chk("busy_after_start", DW'(busy_o), DW'(1));
      chk("ready_after_start", DW'(ready_o), DW'(total > 0));
      if (total == 0) begin
         chk("zero_done", DW'(done_o), DW'(1));
         @(posedge clk); #1;
         chk("zero_idle_busy", DW'(busy_o), DW'(0));
         return;
      end
      k = 0; budget = 0; pat = 0;
      while (k < total && budget < 5000) begin
         case (mode)
            0:       valid = 1'b1;
            1:       valid = (pat % 4 == 0) || (pat % 4 == 3);
            default: valid = 1'($urandom_range(0, 1));
         endcase
         pat++;
         data = dq[k];
         if (extra) begin
            start = 1'($urandom_range(0, 1));
            h_dim = DMW'($urandom); w_dim = DMW'($urandom);
            base = AW'($urandom);
         end
         acc = valid && ready_o;
         @(posedge clk); #1;
         budget++;
         if (acc) k++;
         if (rst_after > 0 && k == rst_after) begin
            valid = 1'b0; start = 1'b0; rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            sbq.delete();
            chk("rst_wr_en", DW'(wr_en), DW'(0));
            chk("rst_addr", DW'(wr_addr), DW'(0));
            chk("rst_data", wr_data, DW'(0));
            chk("rst_ready", DW'(ready_o), DW'(0));
            chk("rst_busy", DW'(busy_o), DW'(0));
            chk("rst_done", DW'(done_o), DW'(0));
            repeat (3) @(posedge clk);
            #1;
            return;
         end
      end
      valid = 1'b0; start = 1'b0;
      if (k < total) begin
         checks++;
         errors++;
         $display("FAIL timeout: accepted %0d of %0d beats", k, total);
         return;
      end
      chk("last_done", DW'(done_o), DW'(1));
      chk("last_ready", DW'(ready_o), DW'(0));
      chk("last_busy", DW'(busy_o), DW'(1));
      @(posedge clk); #1;
      chk("post_busy", DW'(busy_o), DW'(0));
      chk("post_done", DW'(done_o), DW'(0));
      chk("sb_drained", DW'(sbq.size()), DW'(0));
      sbq.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_wr_en", DW'(wr_en), DW'(0));
      chk("reset_addr", DW'(wr_addr), DW'(0));
      chk("reset_data", wr_data, DW'(0));
      chk("reset_ready", DW'(ready_o), DW'(0));
      chk("reset_busy", DW'(busy_o), DW'(0));
      chk("reset_done", DW'(done_o), DW'(0));
      rst = 1'b0;
      mon_en = 1'b1;

      run(32, 32, 12'h100, 0, 0, 1'b0);
      run(64, 64, 12'h000, 0, 0, 1'b0);
      run(32, 32, 12'h040, 1, 0, 1'b0);
      run(0, 17, 12'h123, 0, 0, 1'b0);
      run(9, 0, 12'h321, 0, 0, 1'b0);
      run(33, 1, 12'hFF0, 0, 0, 1'b0);
      run(64, 32, 12'h200, 0, 10, 1'b0);
      run(40, 70, 12'h300, 2, 0, 1'b0);
      run(32, 64, 12'h080, 2, 0, 1'b1);
      run(511, 1, 12'hE00, 0, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         run($urandom_range(0, 130), $urandom_range(0, 130),
             AW'($urandom), 2, 0, 1'($urandom_range(0, 1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
